// File: rtl/mca_downsample_scheduler_pkg.sv
// Shared types and helpers for the downsample scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mca_downsample_scheduler_pkg;

    typedef enum logic [1:0] {
        SCH_IDLE    = 2'd0,
        SCH_WAIT    = 2'd1,
        SCH_CAPTURE = 2'd2
    } sch_state_t;

    // Bits needed for a counter spanning 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mca_sample_fifo2.sv
// Two-entry valid/ready buffer with a registered head entry.
// Latency: a push into an empty buffer is visible on the head one cycle later.
// Backpressure: push while full with no pop is dropped and flagged on o_drop.
module mca_sample_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_pop_vld,
    input  logic             i_pop_rdy,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_drop
);

    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_pop;

    assign w_pop     = (r_cnt != 2'd0) && i_pop_rdy;
    assign o_pop_vld = (r_cnt != 2'd0);
    assign o_pop_dat = r_head;
    assign o_drop    = i_push_vld && (r_cnt == 2'd2) && !i_pop_rdy;

    // Occupancy and storage update; simultaneous push and pop are both honoured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (i_push_vld) begin
                        r_head <= i_push_dat;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({i_push_vld, w_pop})
                        2'b11: r_head <= i_push_dat;
                        2'b10: begin
                            r_tail <= i_push_dat;
                            r_cnt  <= 2'd2;
                        end
                        2'b01: r_cnt <= 2'd0;
                        default: r_cnt <= r_cnt;
                    endcase
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_push_vld) begin
                            r_tail <= i_push_dat;
                        end else begin
                            r_cnt <= 2'd1;
                        end
                    end
                end
                default: r_cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/mca_downsample_scheduler.sv
// Issues one adder start per DOWNSAMPLE_FACTOR accepted columns and captures the result.
// Latency: start one cycle after the last column; sample on out_* ADDER_LATENCY+1 cycles after start.
// Backpressure: 2-entry output buffer; a capture into a full buffer is dropped and sets overflow.
module mca_downsample_scheduler
    import mca_downsample_scheduler_pkg::*;
#(
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int DOWNSAMPLE_FACTOR = 16,
    parameter int ADDER_LATENCY     = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                in_valid,
    output logic                                adder_start,
    input  logic signed [WIDTH_COEFFICIENT-1:0] adder_sample,
    output logic signed [WIDTH_COEFFICIENT-1:0] out_sample,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                overrun,
    output logic                                overflow,
    input  logic                                clear_err
);

    localparam int CNT_W = cnt_width(DOWNSAMPLE_FACTOR);
    localparam int LAT_W = cnt_width(ADDER_LATENCY);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DOWNSAMPLE_FACTOR - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ADDER_LATENCY - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [LAT_W-1:0] r_lat;
    sch_state_t       r_state;
    logic             r_start;
    logic             r_overrun;
    logic             r_overflow;

    logic             w_col_acc;
    logic             w_start_due;
    logic             w_capture;
    logic             w_overrun_set;
    logic             w_drop;

    assign w_col_acc     = in_valid && enable;
    assign w_start_due   = w_col_acc && (r_cnt == CNT_MAX);
    assign w_capture     = (r_state == SCH_CAPTURE);
    // A start falling due while waiting on the adder is lost; CAPTURE can always chain a new start.
    assign w_overrun_set = w_start_due && (r_state == SCH_WAIT);

    assign adder_start = r_start;
    assign busy        = (r_state != SCH_IDLE);
    assign overrun     = r_overrun;
    assign overflow    = r_overflow;

    // Column counter: advances on accepted columns, wraps regardless of whether the start is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_col_acc) begin
            r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Sequencer: registered start pulse, fixed-latency wait, one-cycle capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SCH_IDLE;
            r_start <= 1'b0;
            r_lat   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                SCH_IDLE: begin
                    if (w_start_due) begin
                        r_start <= 1'b1;
                        r_lat   <= LAT_INIT;
                        r_state <= SCH_WAIT;
                    end
                end
                SCH_WAIT: begin
                    if (r_lat == '0) begin
                        r_state <= SCH_CAPTURE;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                SCH_CAPTURE: begin
                    if (w_start_due) begin
                        r_start <= 1'b1;
                        r_lat   <= LAT_INIT;
                        r_state <= SCH_WAIT;
                    end else begin
                        r_state <= SCH_IDLE;
                    end
                end
                default: r_state <= SCH_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error event takes priority over clear_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clear_err) begin
                r_overrun <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    mca_sample_fifo2 #(
        .WIDTH(WIDTH_COEFFICIENT)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push_vld(w_capture),
        .i_push_dat(adder_sample),
        .o_pop_vld (out_valid),
        .i_pop_rdy (out_ready),
        .o_pop_dat (out_sample),
        .o_drop    (w_drop)
    );

endmodule
